// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets, STATUS bits, FSM encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mmio_uart_tx_pkg;

  // Register offsets within the 32-byte window, taken from dm_addr[4:3]
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_BUSY   = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 8;
  localparam int STAT_CNT_HI = 15;

  // dm_rd_ctrl / dm_wr_ctrl value meaning "no access", shared with ctrl and dram_ctrl
  localparam logic [2:0] DM_CTRL_NONE = 3'b000;

  // Serial FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // A divider of zero would never reach a bit boundary, so it is treated as one clock per bit
  function automatic logic [15:0] div_effective(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Generic synchronous FIFO: circular buffer with wrapping pointers and a separate occupancy count.
// Latency: a pushed entry is visible on dout/empty one clock after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; the caller reads full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy independently
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus, fed from a TX FIFO.
// Latency: reads are combinational; a byte written into an empty FIFO starts its frame on the next edge.
// Backpressure: none toward the core; a push to a full FIFO is dropped and sets the sticky overflow bit.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dm_rd_ctrl,
  input  logic [2:0]  dm_wr_ctrl,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_din,
  output logic [63:0] dm_dout,
  output logic        sel,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    offset;
  logic          rd_en;
  logic          wr_en;
  logic          push;
  logic          load;
  logic          baud_end;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   div_reg;
  logic [15:0]   div_eff;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overflow;
  tx_state_t     state;
  logic          unused_bus_bits;

  // Width and low address bits are don't-care for this peripheral
  assign unused_bus_bits = ^{dm_addr[2:0], dm_din[63:16]};

  assign sel    = (dm_addr[63:5] == BASE_ADDR[63:5]);
  assign offset = dm_addr[4:3];
  assign rd_en  = sel && (dm_rd_ctrl != DM_CTRL_NONE);
  assign wr_en  = sel && (dm_wr_ctrl != DM_CTRL_NONE);
  assign push   = wr_en && (offset == UART_TXDATA) && !fifo_full;

  assign baud_end = (baud_cnt == div_eff - 16'd1);
  // A new frame is loaded from IDLE, or straight out of STOP so frames run back to back
  assign load     = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dm_din[7:0]),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus writes: DIV update, overflow set on a dropped push, overflow clear on any STATUS write
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_reg  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else if (wr_en) begin
      case (offset)
        UART_TXDATA: if (fifo_full) overflow <= 1'b1;
        UART_STATUS: overflow <= 1'b0;
        UART_DIV:    div_reg  <= dm_din[15:0];
        default:     ;
      endcase
    end
  end

  // Combinational read mux; zero whenever the window is not being read
  always_comb begin
    dm_dout = 64'h0;
    if (rd_en) begin
      case (offset)
        UART_STATUS: begin
          dm_dout[STAT_FULL]                = fifo_full;
          dm_dout[STAT_EMPTY]               = fifo_empty;
          dm_dout[STAT_BUSY]                = (state != ST_IDLE);
          dm_dout[STAT_OVF]                 = overflow;
          dm_dout[STAT_CNT_HI:STAT_CNT_LO]  = 8'(fifo_count);
        end
        UART_DIV: dm_dout[15:0] = div_reg;
        default:  dm_dout = 64'h0;
      endcase
    end
  end

  // Serial FSM: start bit, 8 data bits LSB first, stop bit; divider is latched once per frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      div_eff  <= div_effective(DEFAULT_DIV);
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shift    <= fifo_dout;
            div_eff  <= div_effective(div_reg);
            baud_cnt <= 16'd0;
            state    <= ST_START;
            tx       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            state    <= ST_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= 16'd0;
            if (load) begin
              shift   <= fifo_dout;
              div_eff <= div_effective(div_reg);
              state   <= ST_START;
              tx      <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO overflow, divider handling, reset.
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge.
// Backpressure: not applicable.
module tb_mmio_uart_tx;

  localparam logic [63:0] BASE     = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A_TXDATA = BASE + 64'h00;
  localparam logic [63:0] A_STATUS = BASE + 64'h08;
  localparam logic [63:0] A_DIV    = BASE + 64'h10;
  localparam logic [63:0] A_RSVD   = BASE + 64'h18;
  localparam logic [63:0] A_OUT    = BASE + 64'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dm_rd_ctrl;
  logic [2:0]  dm_wr_ctrl;
  logic [63:0] dm_addr;
  logic [63:0] dm_din;
  logic [63:0] dm_dout;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .dm_rd_ctrl (dm_rd_ctrl),
    .dm_wr_ctrl (dm_wr_ctrl),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_dout    (dm_dout),
    .sel        (sel),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // One store, consumed at the next rising edge; returns on the following falling edge
  task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
    dm_addr    = a;
    dm_din     = d;
    dm_wr_ctrl = 3'b011;
    @(negedge clk);
    dm_wr_ctrl = 3'b000;
  endtask

  // Combinational load, no clock consumed
  task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
    dm_addr    = a;
    dm_rd_ctrl = 3'b011;
    #1;
    d          = dm_dout;
    dm_rd_ctrl = 3'b000;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Samples tx once per cycle for one whole frame, starting with the next falling edge
  task automatic check_frame(input logic [7:0] b, input int div, input string name);
    int bad = 0;
    for (int i = 0; i < 10 * div; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame_bit(b, i / div)) begin
        errors++;
        if (bad == 0)
          $display("FAIL %s: sample %0d tx=%b expected %b", name, i, tx, frame_bit(b, i / div));
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 64'h2); end
    bus_read(A_DIV, d);
    checks++;
    if (d !== 64'd868) begin errors++; $display("FAIL reset_div: got %0d expected 868", d); end
  endtask

  task automatic test_decode();
    logic [63:0] d;
    dm_addr = A_OUT;
    dm_rd_ctrl = 3'b011;
    #1;
    checks++;
    if (sel !== 1'b0) begin errors++; $display("FAIL out_sel: got %b expected 0", sel); end
    checks++;
    if (dm_dout !== 64'h0) begin errors++; $display("FAIL out_read: got %h expected 0", dm_dout); end
    dm_rd_ctrl = 3'b000;
    bus_write(A_OUT, 64'h41);
    bus_write(BASE + 64'h30, 64'h7);
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL out_write_tx: got %b expected 1", tx); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL out_write_status: got %h expected 2", d); end
    bus_read(A_DIV, d);
    checks++;
    if (d !== 64'd868) begin errors++; $display("FAIL out_write_div: got %0d expected 868", d); end
    bus_write(A_RSVD, 64'hFFFF_FFFF_FFFF_FFFF);
    dm_addr = A_RSVD;
    dm_rd_ctrl = 3'b001;
    #1;
    checks++;
    if (sel !== 1'b1) begin errors++; $display("FAIL rsvd_sel: got %b expected 1", sel); end
    checks++;
    if (dm_dout !== 64'h0) begin errors++; $display("FAIL rsvd_read: got %h expected 0", dm_dout); end
    dm_rd_ctrl = 3'b000;
    bus_read(A_DIV, d);
    checks++;
    if (d !== 64'd868) begin errors++; $display("FAIL rsvd_write_div: got %0d expected 868", d); end
    dm_addr = A_STATUS;
    #1;
    checks++;
    if (dm_dout !== 64'h0) begin errors++; $display("FAIL no_rd_strobe: got %h expected 0", dm_dout); end
    bus_read(BASE + 64'h0F, d);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL low_addr_ignored: got %h expected 2", d); end
  endtask

  task automatic test_basic_frame();
    logic [63:0] d;
    int bad;
    bus_write(A_DIV, 64'hFFFF_FFFF_FFFF_0004);
    bus_read(A_DIV, d);
    checks++;
    if (d !== 64'd4) begin errors++; $display("FAIL div_write: got %h expected 4", d); end
    bus_write(A_TXDATA, 64'h55);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame_bit(8'h55, i / 4)) begin
        errors++;
        if (bad == 0) $display("FAIL frame55_tx: sample %0d tx=%b expected %b", i, tx, frame_bit(8'h55, i / 4));
        bad++;
      end
      bus_read(A_STATUS, d);
      checks++;
      if (d[2] !== 1'b1) begin
        errors++;
        if (bad == 0) $display("FAIL frame55_busy: sample %0d busy=%b expected 1", i, d[2]);
        bad++;
      end
    end
    @(negedge clk);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL frame55_done: status %h expected 2", d); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    bus_write(A_DIV, 64'd2);
    fork
      begin
        for (int k = 0; k < 9; k++) begin
          bus_write(A_TXDATA, 64'(8'hC0 + 8'(k * 7)));
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 64'h0805) begin errors++; $display("FAIL fill_status: got %h expected 0805", d); end
        bus_write(A_TXDATA, 64'h77);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 64'h080D) begin errors++; $display("FAIL overflow_set: got %h expected 080d", d); end
        bus_write(A_STATUS, 64'h0);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 64'h0805) begin errors++; $display("FAIL overflow_clear: got %h expected 0805", d); end
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
          check_frame(8'hC0 + 8'(k * 7), 2, "b2b_frame");
        end
      end
    join
    repeat (6) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_tx: got %b expected 1", tx); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL b2b_drained: got %h expected 2", d); end
  endtask

  task automatic test_div_zero();
    logic [63:0] d;
    bus_write(A_DIV, 64'd0);
    bus_read(A_DIV, d);
    checks++;
    if (d !== 64'd0) begin errors++; $display("FAIL div0_read: got %0d expected 0", d); end
    fork
      begin
        bus_write(A_TXDATA, 64'hA3);
        bus_write(A_TXDATA, 64'h3C);
        bus_write(A_DIV, 64'd8);
      end
      begin
        @(negedge clk);
        check_frame(8'hA3, 1, "div0_frame");
        check_frame(8'h3C, 8, "div8_next_frame");
      end
    join
    bus_read(A_DIV, d);
    checks++;
    if (d !== 64'd8) begin errors++; $display("FAIL div8_read: got %0d expected 8", d); end
    @(negedge clk);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL div_frames_done: got %h expected 2", d); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] d;
    int lows;
    bus_write(A_DIV, 64'd4);
    bus_write(A_TXDATA, 64'hFF);
    bus_write(A_TXDATA, 64'h01);
    bus_write(A_TXDATA, 64'h02);
    repeat (10) @(negedge clk);
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h0204) begin errors++; $display("FAIL pre_reset_status: got %h expected 0204", d); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", tx); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL midreset_status: got %h expected 2", d); end
    bus_read(A_DIV, d);
    checks++;
    if (d !== 64'd868) begin errors++; $display("FAIL midreset_div: got %0d expected 868", d); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin errors++; $display("FAIL no_frames_after_reset: %0d low cycles, expected 0", lows); end
  endtask

  initial begin
    rst        = 1'b0;
    dm_rd_ctrl = 3'b000;
    dm_wr_ctrl = 3'b000;
    dm_addr    = 64'h0;
    dm_din     = 64'h0;
    @(negedge clk);
    test_reset();
    test_decode();
    test_basic_frame();
    test_back_to_back();
    test_div_zero();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
